// File: rtl/prog_encoder_pkg.sv
// Shared instruction-set definitions for the program encoder and the decoder.
// Holds the mnemonic codes, the 6-bit opcode constants, the instruction field
// widths/positions and the encoder FSM state type.
// Word layout: {opcode[5:0], rd[4:0], rs[4:0], imm[7:0]} (24 bits).
package prog_encoder_pkg;

  localparam int unsigned MnemW  = 4;
  localparam int unsigned OpW    = 6;
  localparam int unsigned RegW   = 5;
  localparam int unsigned ImmW   = 8;
  localparam int unsigned InstrW = OpW + 2 * RegW + ImmW;

  localparam int unsigned ImmLsb = 0;
  localparam int unsigned RsLsb  = ImmLsb + ImmW;
  localparam int unsigned RdLsb  = RsLsb + RegW;
  localparam int unsigned OpLsb  = RdLsb + RegW;

  typedef enum logic [MnemW-1:0] {
    MnAdd  = 4'h0,
    MnSub  = 4'h1,
    MnAddi = 4'h2,
    MnSubi = 4'h3,
    MnBeq  = 4'h4,
    MnBnq  = 4'h5,
    MnJmp  = 4'h6,
    MnMult = 4'h7,
    MnStin = 4'h8,
    MnLout = 4'h9
  } mnem_e;

  localparam logic [OpW-1:0] OpAdd  = 6'h01;
  localparam logic [OpW-1:0] OpSub  = 6'h02;
  localparam logic [OpW-1:0] OpAddi = 6'h03;
  localparam logic [OpW-1:0] OpSubi = 6'h04;
  localparam logic [OpW-1:0] OpBeq  = 6'h05;
  localparam logic [OpW-1:0] OpBnq  = 6'h06;
  localparam logic [OpW-1:0] OpJmp  = 6'h07;
  localparam logic [OpW-1:0] OpMult = 6'h08;
  localparam logic [OpW-1:0] OpStin = 6'h09;
  localparam logic [OpW-1:0] OpLout = 6'h0A;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone,
    StError
  } enc_state_e;

  // Undefined mnemonic codes map to opcode 0, which no instruction uses.
  function automatic logic [OpW-1:0] opcode_of(input logic [MnemW-1:0] mnem);
    logic [OpW-1:0] op;
    op = '0;
    case (mnem)
      MnAdd:   op = OpAdd;
      MnSub:   op = OpSub;
      MnAddi:  op = OpAddi;
      MnSubi:  op = OpSubi;
      MnBeq:   op = OpBeq;
      MnBnq:   op = OpBnq;
      MnJmp:   op = OpJmp;
      MnMult:  op = OpMult;
      MnStin:  op = OpStin;
      MnLout:  op = OpLout;
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational mnemonic-to-word packer.
// Ports:
//   mnem_i  - mnemonic code
//   rd_i    - destination register index
//   rs_i    - source register index
//   imm_i   - immediate / PC-relative offset
//   word_o  - encoded 24-bit instruction word, unused fields forced to zero
//   legal_o - 1 when mnem_i is a defined mnemonic
module instr_pack
  import prog_encoder_pkg::*;
(
  input  logic [MnemW-1:0]  mnem_i,
  input  logic [RegW-1:0]   rd_i,
  input  logic [RegW-1:0]   rs_i,
  input  logic [ImmW-1:0]   imm_i,
  output logic [InstrW-1:0] word_o,
  output logic              legal_o
);

  logic [RegW-1:0] rd_f;
  logic [RegW-1:0] rs_f;
  logic [ImmW-1:0] imm_f;

  always_comb begin
    legal_o = 1'b1;
    rd_f    = rd_i;
    rs_f    = rs_i;
    imm_f   = imm_i;
    case (mnem_i)
      MnAdd, MnSub, MnMult:        imm_f = '0;
      MnAddi, MnSubi, MnStin:      rs_f  = '0;
      MnBeq, MnBnq, MnJmp, MnLout: rd_f  = '0;
      default:                     legal_o = 1'b0;
    endcase
  end

  assign word_o = {opcode_of(mnem_i), rd_f, rs_f, imm_f};

endmodule

// File: rtl/prog_encoder.sv
// Program encoder: accepts instruction-field beats over a valid/ready
// handshake, packs each into a 24-bit word and writes it to program memory
// one cycle later at consecutive addresses starting from 0.
// Ports:
//   clk, n_reset            - clock, synchronous active-low reset
//   start                   - begin a new load at address 0 (ignored mid-load)
//   in_valid/in_ready       - beat handshake
//   in_last                 - final instruction of the program
//   in_mnem/in_rd/in_rs/in_imm - instruction fields
//   pm_we/pm_addr/pm_wdata  - registered program-memory write port
//   done/full/err           - completion, memory exhausted, illegal mnemonic
//   instr_count             - words written since start
// Build option: PROG_ENCODER_CHECK_EN turns an undefined mnemonic into an
// error (ERROR state, err=1); otherwise such beats are silently dropped.
module prog_encoder
  import prog_encoder_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 64,
  parameter int unsigned AW         = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [MnemW-1:0]  in_mnem,
  input  logic [RegW-1:0]   in_rd,
  input  logic [RegW-1:0]   in_rs,
  input  logic [ImmW-1:0]   in_imm,
  output logic              pm_we,
  output logic [AW-1:0]     pm_addr,
  output logic [InstrW-1:0] pm_wdata,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [AW:0]       instr_count
);

  localparam logic [AW-1:0] LastAddr = AW'(PROG_DEPTH - 1);
  localparam logic [AW:0]   CountOne = {{AW{1'b0}}, 1'b1};

  enc_state_e        state_q, state_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [InstrW-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [InstrW-1:0] packed_word;
  logic              legal;
  logic              hs;
  logic              at_last_addr;

  instr_pack u_instr_pack (
    .mnem_i  (in_mnem),
    .rd_i    (in_rd),
    .rs_i    (in_rs),
    .imm_i   (in_imm),
    .word_o  (packed_word),
    .legal_o (legal)
  );

  assign in_ready     = (state_q == StLoad) && !full_q;
  assign hs           = in_valid && in_ready;
  // count_q is also the address the next accepted word will land on.
  assign at_last_addr = (count_q[AW-1:0] == LastAddr);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = done_q;
    full_d  = full_q;
    err_d   = err_q;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
          addr_d  = '0;
          done_d  = 1'b0;
          full_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (hs && legal) begin
          we_d    = 1'b1;
          addr_d  = count_q[AW-1:0];
          wdata_d = packed_word;
          count_d = count_q + CountOne;
          // Last address ends the load whether or not in_last is set.
          if (in_last || at_last_addr) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
          if (at_last_addr) begin
            full_d = 1'b1;
          end
        end
`ifdef PROG_ENCODER_CHECK_EN
        if (hs && !legal) begin
          err_d   = 1'b1;
          state_d = StError;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign pm_we       = we_q;
  assign pm_addr     = addr_q;
  assign pm_wdata    = wdata_q;
  assign done        = done_q;
  assign full        = full_q;
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder: a table of instruction vectors loaded as
// one program, plus hand-written sequences for the multi-cycle corner cases.
// A second instance with PROG_DEPTH=4 covers memory exhaustion.
module tb_prog_encoder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        start;
  logic        start4;
  logic        in_valid;
  logic        in_last;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs;
  logic [7:0]  in_imm;

  logic        in_ready, pm_we, done, full, err;
  logic [5:0]  pm_addr;
  logic [23:0] pm_wdata;
  logic [6:0]  instr_count;

  logic        in_ready4, pm_we4, done4, full4, err4;
  logic [1:0]  pm_addr4;
  logic [23:0] pm_wdata4;
  logic [2:0]  instr_count4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_encoder dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_mnem     (in_mnem),
    .in_rd       (in_rd),
    .in_rs       (in_rs),
    .in_imm      (in_imm),
    .pm_we       (pm_we),
    .pm_addr     (pm_addr),
    .pm_wdata    (pm_wdata),
    .done        (done),
    .full        (full),
    .err         (err),
    .instr_count (instr_count)
  );

  prog_encoder #(.PROG_DEPTH(4)) dut4 (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start4),
    .in_valid    (in_valid),
    .in_ready    (in_ready4),
    .in_last     (in_last),
    .in_mnem     (in_mnem),
    .in_rd       (in_rd),
    .in_rs       (in_rs),
    .in_imm      (in_imm),
    .pm_we       (pm_we4),
    .pm_addr     (pm_addr4),
    .pm_wdata    (pm_wdata4),
    .done        (done4),
    .full        (full4),
    .err         (err4),
    .instr_count (instr_count4)
  );

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [7:0]  imm;
    logic        last;
    logic [23:0] word;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] m, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [7:0] imm, input logic last);
    in_valid = 1'b1;
    in_mnem  = m;
    in_rd    = rd;
    in_rs    = rs;
    in_imm   = imm;
    in_last  = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // word = op<<18 | rd<<13 | rs<<8 | imm, with unused fields zeroed
    vecs[0] = '{4'h0, 5'd1,  5'd2,  8'h33, 1'b0, 24'h042200}; // ADD  (imm dropped)
    vecs[1] = '{4'h4, 5'd7,  5'd4,  8'hFE, 1'b0, 24'h1404FE}; // BEQ  (rd dropped)
    vecs[2] = '{4'h1, 5'd31, 5'd31, 8'hFF, 1'b0, 24'h0BFF00}; // SUB
    vecs[3] = '{4'h2, 5'd3,  5'd9,  8'h05, 1'b0, 24'h0C6005}; // ADDI (rs dropped)
    vecs[4] = '{4'h3, 5'd10, 5'd1,  8'h80, 1'b0, 24'h114080}; // SUBI
    vecs[5] = '{4'h5, 5'd5,  5'd6,  8'h10, 1'b0, 24'h180610}; // BNQ
    vecs[6] = '{4'h6, 5'd1,  5'd0,  8'hF0, 1'b0, 24'h1C00F0}; // JMP
    vecs[7] = '{4'h7, 5'd2,  5'd3,  8'h7F, 1'b0, 24'h204300}; // MULT
    vecs[8] = '{4'h8, 5'd4,  5'd5,  8'h01, 1'b0, 24'h248001}; // STIN
    vecs[9] = '{4'h9, 5'd8,  5'd12, 8'h22, 1'b1, 24'h280C22}; // LOUT last

    n_reset = 1'b0;
    start   = 1'b0;
    start4  = 1'b0;
    in_mnem = 4'h0;
    in_rd   = 5'd0;
    in_rs   = 5'd0;
    in_imm  = 8'h00;
    idle_in();
    step();
    step();
    chk("reset pm_we",       32'(pm_we), 0);
    chk("reset pm_addr",     32'(pm_addr), 0);
    chk("reset pm_wdata",    32'(pm_wdata), 0);
    chk("reset done",        32'(done), 0);
    chk("reset full",        32'(full), 0);
    chk("reset err",         32'(err), 0);
    chk("reset instr_count", 32'(instr_count), 0);
    chk("reset in_ready",    32'(in_ready), 0);
    n_reset = 1'b1;

    // Table: whole program back to back, one write per cycle
    do_start();
    chk("tbl in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      beat(vecs[i].mnem, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].last);
      step();
      chk("tbl pm_we",    32'(pm_we), 1);
      chk("tbl pm_addr",  32'(pm_addr), 32'(i));
      chk("tbl pm_wdata", 32'(pm_wdata), 32'(vecs[i].word));
      chk("tbl count",    32'(instr_count), 32'(i + 1));
      chk("tbl done",     32'(done), 32'(vecs[i].last));
      chk("tbl full",     32'(full), 0);
    end
    idle_in();
    step();
    chk("tbl post pm_we",    32'(pm_we), 0);
    chk("tbl post done",     32'(done), 1);
    chk("tbl post in_ready", 32'(in_ready), 0);
    chk("tbl post count",    32'(instr_count), 10);

    // Single ADDI with in_last: restart from DONE
    do_start();
    chk("one done cleared",  32'(done), 0);
    chk("one count cleared", 32'(instr_count), 0);
    beat(4'h2, 5'd3, 5'd0, 8'h05, 1'b1);
    step();
    idle_in();
    chk("one pm_we",    32'(pm_we), 1);
    chk("one pm_addr",  32'(pm_addr), 0);
    chk("one pm_wdata", 32'(pm_wdata), 32'h0C6005);
    chk("one done",     32'(done), 1);
    chk("one count",    32'(instr_count), 1);

    // in_valid 1,0,1; start during LOAD must be ignored
    do_start();
    beat(4'h0, 5'd1, 5'd2, 8'h00, 1'b0);
    step();
    chk("gap w0 pm_we",   32'(pm_we), 1);
    chk("gap w0 pm_addr", 32'(pm_addr), 0);
    idle_in();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gap idle pm_we",   32'(pm_we), 0);
    chk("gap idle pm_addr", 32'(pm_addr), 0);
    beat(4'h0, 5'd1, 5'd2, 8'h00, 1'b1);
    step();
    idle_in();
    chk("gap w1 pm_we",   32'(pm_we), 1);
    chk("gap w1 pm_addr", 32'(pm_addr), 1);
    chk("gap w1 count",   32'(instr_count), 2);
    chk("gap w1 done",    32'(done), 1);

    // Undefined mnemonic 4'hF mid-program
    do_start();
    beat(4'h0, 5'd1, 5'd2, 8'h00, 1'b0);
    step();
    beat(4'hF, 5'd1, 5'd1, 8'h01, 1'b0);
    step();
    chk("bad pm_we", 32'(pm_we), 0);
`ifdef PROG_ENCODER_CHECK_EN
    chk("bad err",      32'(err), 1);
    chk("bad in_ready", 32'(in_ready), 0);
    idle_in();
    step();
    chk("bad hold pm_we", 32'(pm_we), 0);
    chk("bad hold err",   32'(err), 1);
    do_start();
    chk("bad restart err",      32'(err), 0);
    chk("bad restart in_ready", 32'(in_ready), 1);
`else
    chk("bad err",      32'(err), 0);
    chk("bad in_ready", 32'(in_ready), 1);
    chk("bad count",    32'(instr_count), 1);
    beat(4'h2, 5'd3, 5'd0, 8'h05, 1'b1);
    step();
    idle_in();
    chk("bad next pm_we",    32'(pm_we), 1);
    chk("bad next pm_addr",  32'(pm_addr), 1);
    chk("bad next pm_wdata", 32'(pm_wdata), 32'h0C6005);
    chk("bad next count",    32'(instr_count), 2);
    chk("bad next err",      32'(err), 0);
`endif

    // Reset while a beat is pending
    do_start();
    beat(4'h0, 5'd1, 5'd2, 8'h00, 1'b0);
    step();
    chk("rst w0 pm_we", 32'(pm_we), 1);
    beat(4'h1, 5'd31, 5'd31, 8'hFF, 1'b0);
    n_reset = 1'b0;
    step();
    idle_in();
    n_reset = 1'b1;
    chk("rst pm_we",    32'(pm_we), 0);
    chk("rst pm_addr",  32'(pm_addr), 0);
    chk("rst pm_wdata", 32'(pm_wdata), 0);
    chk("rst count",    32'(instr_count), 0);
    chk("rst done",     32'(done), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    do_start();
    beat(4'h8, 5'd4, 5'd5, 8'h01, 1'b1);
    step();
    idle_in();
    chk("rst reload pm_we",    32'(pm_we), 1);
    chk("rst reload pm_addr",  32'(pm_addr), 0);
    chk("rst reload pm_wdata", 32'(pm_wdata), 32'h248001);
    chk("rst reload count",    32'(instr_count), 1);

    // PROG_DEPTH=4: five beats without in_last
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("full in_ready", 32'(in_ready4), 1);
    beat(4'h0, 5'd1, 5'd2, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("full pm_we",    32'(pm_we4), 1);
      chk("full pm_addr",  32'(pm_addr4), 32'(k));
      chk("full pm_wdata", 32'(pm_wdata4), 32'h042200);
      chk("full count",    32'(instr_count4), 32'(k + 1));
      chk("full flag",     32'(full4), 32'(k == 3));
      chk("full done",     32'(done4), 32'(k == 3));
      chk("full ready",    32'(in_ready4), 32'(k != 3));
    end
    step();
    idle_in();
    chk("full 5th pm_we",   32'(pm_we4), 0);
    chk("full 5th pm_addr", 32'(pm_addr4), 3);
    chk("full 5th count",   32'(instr_count4), 4);
    chk("full 5th flag",    32'(full4), 1);
    chk("full 5th done",    32'(done4), 1);
    chk("full 5th err",     32'(err4), 0);
    step();
    chk("full idle pm_we", 32'(pm_we4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_encoder.md
PROG_ENCODER -- requirements
Module: prog_encoder

Interface
REQ-001 Parameter PROG_DEPTH, default 64, SHALL set the number of program-memory words (power of two, 4..256).
REQ-002 Parameter AW, default $clog2(PROG_DEPTH), SHALL set the program-memory address width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 n_reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin loading at address 0.
REQ-006 in_valid  input  1  SHALL qualify the instruction-field inputs.
REQ-007 in_ready  output  1  SHALL indicate that a beat is accepted this cycle.
REQ-008 in_last  input  1  SHALL mark the final instruction of a program.
REQ-009 in_mnem  input  4  SHALL carry the mnemonic code (ADD, SUB, ADDI, SUBI, BEQ, BNQ, JMP, MULT, STIN, LOUT).
REQ-010 in_rd, in_rs  input  5 each  SHALL carry the destination and source register indices.
REQ-011 in_imm  input  8  SHALL carry the immediate or PC-relative branch offset (two's complement).
REQ-012 pm_we  output  1  SHALL be the program-memory write strobe.
REQ-013 pm_addr  output  AW  SHALL be the program-memory write address.
REQ-014 pm_wdata  output  24  SHALL be the encoded instruction word.
REQ-015 done, full, err  output  1 each  SHALL report completion, memory exhausted and illegal input.
REQ-016 instr_count  output  AW+1  SHALL report the number of words written.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, DONE and ERROR.
REQ-018 A handshake SHALL occur when in_valid && in_ready; in_ready SHALL be 1 only in LOAD with no full condition.
REQ-019 The encoding SHALL be pm_wdata = {opcode[5:0], rd[4:0], rs[4:0], imm[7:0]}, with the opcode taken from the shared opcode constants the decoder consumes.
REQ-020 Unused fields SHALL be zero: imm for ADD/SUB/MULT; rs for ADDI/SUBI/STIN; rd for BEQ/BNQ/JMP/LOUT.
REQ-021 Latency SHALL be one cycle: a beat accepted in cycle N SHALL produce pm_we=1 in cycle N+1 with registered pm_addr and pm_wdata.
REQ-022 pm_addr SHALL start at 0 and increment by 1 after each write; instr_count SHALL equal the number of writes since start.
REQ-023 IDLE->LOAD SHALL occur on start; the address and count SHALL clear, and done, full and err SHALL clear.
REQ-024 LOAD->DONE SHALL occur on a beat with in_last=1 and done SHALL rise in the cycle of that beat's write.
REQ-025 Write to address PROG_DEPTH-1 without in_last SHALL set full=1 and move to DONE; no wrap-around to 0 SHALL occur.
REQ-026 in_last together with the final address SHALL set both done and full.
REQ-027 start in LOAD SHALL be ignored; start in DONE or ERROR SHALL restart as in REQ-023.
REQ-028 in_valid outside LOAD SHALL have no effect.

Reset
REQ-029 While n_reset=0 at a clock edge, the state SHALL become IDLE and pm_we, pm_addr, pm_wdata, done, full, err, instr_count and in_ready SHALL all be 0.
REQ-030 Reset mid-LOAD SHALL discard any pending registered write, so pm_we=0 in the following cycle.

Configuration
REQ-031 With macro PROG_ENCODER_CHECK_EN defined, an undefined in_mnem code SHALL cause no write, set err=1 and move to ERROR.
REQ-032 Without PROG_ENCODER_CHECK_EN, an undefined code SHALL be accepted and dropped (no write, address unchanged) and err SHALL stay 0.

Structure
REQ-033 The mnemonic enum, opcode constants and instruction field widths and positions SHALL live in a shared package that is also used by the decoder.
REQ-034 The mnemonic-to-word mapping SHALL be a combinational sub-module named instr_pack; the FSM, counters and output register SHALL live in prog_encoder.

Verification
REQ-035 Start, then ADDI rd=3 rs=0 imm=0x05 with in_last=1 -> one cycle later pm_we=1, pm_addr=0, pm_wdata={ADDI,5'd3,5'd0,8'h05}, done=1, instr_count=1.
REQ-036 Start, then 3 back-to-back beats (ADD, BEQ imm=0xFE, LOUT last) -> writes to addresses 0, 1, 2 on consecutive cycles, BEQ word imm field=0xFE, done after the third write.
REQ-037 PROG_DEPTH=4 with 5 beats and no in_last -> writes to addresses 0..3, full=1 and done=1, in_ready=0, the fifth beat is never accepted and pm_addr never returns to 0.
REQ-038 in_valid toggling 1,0,1 with in_ready high -> exactly 2 writes, and the address advances only on handshakes.
REQ-039 Undefined code 4'hF mid-program -> with PROG_ENCODER_CHECK_EN: err=1, state ERROR, no write; without it: no write, the next beat is written to the same address.
REQ-040 n_reset=0 in the cycle after a beat -> no write appears, all outputs are 0, and a following start reloads from address 0.
